// File: rtl/bidir_bus_ctrl.sv
// Half-duplex pad bus sequencer: turns single host read/write requests into
// timed pad drive, write/read strobes and sampled read data.
module bidir_bus_ctrl #(
   parameter int N       = 8,
   parameter int SETUP   = 2,
   parameter int HOLD    = 1,
   parameter int TA      = 1,
   parameter int RD_WAIT = 2
) (
   input  logic         i_clk,
   input  logic         i_nreset,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic         i_req_write,
   input  logic [N-1:0] i_req_wdata,
   output logic         o_rsp_valid,
   output logic [N-1:0] o_rsp_data,
   output logic [N-1:0] o_pad_oe,
   output logic [N-1:0] o_pad_out,
   input  logic [N-1:0] i_pad_in,
   output logic         o_wr_stb,
   output logic         o_rd_stb,
   output logic         o_busy
);

   localparam int MAX_SH  = (SETUP > HOLD) ? SETUP : HOLD;
   localparam int MAX_TR  = (TA > RD_WAIT) ? TA : RD_WAIT;
   localparam int MAXP    = (MAX_SH > MAX_TR) ? MAX_SH : MAX_TR;
   localparam int CW      = $clog2(MAXP + 1);

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
   localparam logic [CW-1:0] HOLD_LD  = (HOLD > 0) ? CW'(HOLD - 1) : {CW{1'b0}};
   localparam logic [CW-1:0] TA_LD    = CW'(TA - 1);
   localparam logic [CW-1:0] RW_LD    = CW'(RD_WAIT - 1);
   localparam logic [N-1:0]  ALL_ON   = {N{1'b1}};
   localparam logic [N-1:0]  ALL_OFF  = {N{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WSETUP  = 3'd1,
      S_WSTROBE = 3'd2,
      S_WHOLD   = 3'd3,
      S_TURN    = 3'd4,
      S_RWAIT   = 3'd5
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_pad_oe;
   logic [N-1:0]  r_pad_out;
   logic [N-1:0]  r_rsp_data;
   logic          r_rsp_valid;
   logic          r_wr_stb;
   logic          r_rd_stb;
   logic          w_idle;

   assign w_idle      = (r_state == S_IDLE);
   assign o_req_ready = w_idle;
   assign o_busy      = ~w_idle;
   assign o_pad_oe    = r_pad_oe;
   assign o_pad_out   = r_pad_out;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_valid = r_rsp_valid;
   assign o_wr_stb    = r_wr_stb;
   assign o_rd_stb    = r_rd_stb;

   // Sequencer: every pad-facing output changes only at a state transition, and
   // the async reset releases the pads and strobes without waiting for a clock.
   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state     <= S_IDLE;
         r_cnt       <= CNT_ZERO;
         r_pad_oe    <= ALL_OFF;
         r_pad_out   <= ALL_OFF;
         r_rsp_data  <= ALL_OFF;
         r_rsp_valid <= 1'b0;
         r_wr_stb    <= 1'b0;
         r_rd_stb    <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  if (i_req_write) begin
                     r_state   <= S_WSETUP;
                     r_cnt     <= SETUP_LD;
                     r_pad_oe  <= ALL_ON;
                     r_pad_out <= i_req_wdata;
                  end else begin
                     r_state  <= S_RWAIT;
                     r_cnt    <= RW_LD;
                     r_rd_stb <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WSETUP: begin
               if (r_cnt == CNT_ZERO) begin
                  r_state  <= S_WSTROBE;
                  r_wr_stb <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_WSTROBE: begin
               r_wr_stb <= 1'b0;
               if (HOLD == 0) begin
                  r_state  <= S_TURN;
                  r_cnt    <= TA_LD;
                  r_pad_oe <= ALL_OFF;
               end else begin
                  r_state <= S_WHOLD;
                  r_cnt   <= HOLD_LD;
               end
            end
            S_WHOLD: begin
               if (r_cnt == CNT_ZERO) begin
                  r_state  <= S_TURN;
                  r_cnt    <= TA_LD;
                  r_pad_oe <= ALL_OFF;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_TURN: begin
               if (r_cnt == CNT_ZERO) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_RWAIT: begin
               if (r_cnt == CNT_ZERO) begin
                  r_state     <= S_IDLE;
                  r_rd_stb    <= 1'b0;
                  r_rsp_data  <= i_pad_in;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_cnt    <= CNT_ZERO;
               r_pad_oe <= ALL_OFF;
               r_wr_stb <= 1'b0;
               r_rd_stb <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Scoreboard bench for bidir_bus_ctrl: a default-parameter instance and a
// minimum-timing corner instance, with pad-safety invariants checked every cycle.
module tb_bidir_bus_ctrl;

   localparam int N = 8;
   localparam int D_S = 2, D_H = 1, D_T = 1, D_RW = 2;
   localparam int C_S = 1, C_H = 0, C_T = 1, C_RW = 1;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   logic         req_valid, req_write, req_ready, rsp_valid, wr_stb, rd_stb, busy;
   logic [N-1:0] req_wdata, rsp_data, pad_oe, pad_out, pad_in;
   logic         c_req_valid, c_req_write, c_req_ready, c_rsp_valid, c_wr_stb, c_rd_stb, c_busy;
   logic [N-1:0] c_req_wdata, c_rsp_data, c_pad_oe, c_pad_out, c_pad_in;

   bidir_bus_ctrl #(.N(N), .SETUP(D_S), .HOLD(D_H), .TA(D_T), .RD_WAIT(D_RW)) dut (
      .i_clk(clk), .i_nreset(nreset), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_write(req_write), .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid),
      .o_rsp_data(rsp_data), .o_pad_oe(pad_oe), .o_pad_out(pad_out), .i_pad_in(pad_in),
      .o_wr_stb(wr_stb), .o_rd_stb(rd_stb), .o_busy(busy));

   bidir_bus_ctrl #(.N(N), .SETUP(C_S), .HOLD(C_H), .TA(C_T), .RD_WAIT(C_RW)) dut_c (
      .i_clk(clk), .i_nreset(nreset), .i_req_valid(c_req_valid), .o_req_ready(c_req_ready),
      .i_req_write(c_req_write), .i_req_wdata(c_req_wdata), .o_rsp_valid(c_rsp_valid),
      .o_rsp_data(c_rsp_data), .o_pad_oe(c_pad_oe), .o_pad_out(c_pad_out), .i_pad_in(c_pad_in),
      .o_wr_stb(c_wr_stb), .o_rd_stb(c_rd_stb), .o_busy(c_busy));

   // sel picks which instance the tasks and the monitor look at
   logic         sel = 1'b0;
   logic         m_ready, m_rsp_valid, m_wr, m_rd, m_busy;
   logic [N-1:0] m_rsp_data, m_oe, m_out;
   assign m_ready     = sel ? c_req_ready : req_ready;
   assign m_rsp_valid = sel ? c_rsp_valid : rsp_valid;
   assign m_rsp_data  = sel ? c_rsp_data  : rsp_data;
   assign m_oe        = sel ? c_pad_oe    : pad_oe;
   assign m_out       = sel ? c_pad_out   : pad_out;
   assign m_wr        = sel ? c_wr_stb    : wr_stb;
   assign m_rd        = sel ? c_rd_stb    : rd_stb;
   assign m_busy      = sel ? c_busy      : busy;

   int           n_total = 0;
   int           n_bad   = 0;
   logic [N-1:0] wr_q[$];
   logic [N-1:0] rd_q[$];
   logic         prev_rd = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_req(input logic v, input logic w, input logic [N-1:0] d);
      if (sel) begin
         c_req_valid = v; c_req_write = w; c_req_wdata = d;
      end else begin
         req_valid = v; req_write = w; req_wdata = d;
      end
   endtask

   task automatic set_pad(input logic [N-1:0] p);
      if (sel) c_pad_in = p;
      else     pad_in   = p;
   endtask

   // Raise a request, wait (bounded) for ready, push the expectation and cross the
   // accepting edge. Returns in cycle k+1 with req_valid still high.
   task automatic do_req(input logic w, input logic [N-1:0] d, output int waits);
      waits = 0;
      drv_req(1'b1, w, d);
      while (!m_ready && waits < 64) begin
         tick();
         waits++;
      end
      if (!m_ready) begin
         check_eq("req_timeout", m_ready, 1'b1);
      end else if (w) begin
         wr_q.push_back(d);
      end else begin
         rd_q.push_back(d);
         set_pad(d);
      end
      tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!m_ready && n < 64) begin
         tick();
         n++;
      end
      check_eq("idle_timeout", m_ready, 1'b1);
   endtask

   // Cycle-by-cycle write timing from k+1 through the first ready cycle.
   task automatic write_profile(input int s, input int h, input int t, input logic [N-1:0] d);
      drv_req(1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= s + h + t + 2; i++) begin
         check_eq("w_oe",  m_oe, (i <= s + h + 1) ? 8'hFF : 8'h00);
         check_eq("w_out", m_out, d);
         check_eq("w_stb", m_wr, (i == s + 1));
         check_eq("w_rd",  m_rd, 1'b0);
         check_eq("w_rdy", m_ready, (i == s + h + t + 2));
         if (i < s + h + t + 2) tick();
      end
   endtask

   // Read timing; pad_in carries the right value only in the last wait cycle.
   task automatic read_profile(input int rw, input logic [N-1:0] d);
      drv_req(1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= rw + 1; i++) begin
         set_pad((i == rw) ? d : ~d);
         check_eq("r_stb", m_rd, (i <= rw));
         check_eq("r_oe",  m_oe, 8'h00);
         check_eq("r_rdy", m_ready, (i == rw + 1));
         check_eq("r_vld", m_rsp_valid, (i == rw + 1));
         if (i < rw + 1) tick();
      end
      check_eq("r_data", m_rsp_data, d);
      tick();
      check_eq("r_vld_drop", m_rsp_valid, 1'b0);
      check_eq("r_data_hold", m_rsp_data, d);
   endtask

   // Every-cycle pad safety checks plus scoreboard pops on strobe / response.
   always @(negedge clk) begin
      check_eq("oe_uniform", (m_oe == 8'h00 || m_oe == 8'hFF), 1'b1);
      check_eq("oe_while_rd", (m_oe != 8'h00 && m_rd), 1'b0);
      check_eq("wr_rd_both", (m_wr && m_rd), 1'b0);
      check_eq("oe_after_rd", (prev_rd && m_oe != 8'h00), 1'b0);
      prev_rd <= m_rd;
      if (m_wr) begin
         if (wr_q.size() == 0) check_eq("wr_unexpected", 1'b1, 1'b0);
         else check_eq("wr_data", m_out, wr_q.pop_front());
      end
      if (m_rsp_valid) begin
         if (rd_q.size() == 0) check_eq("rsp_unexpected", 1'b1, 1'b0);
         else check_eq("rsp_data", m_rsp_data, rd_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int gap;
      int prev_exp;
      logic wr;
      logic [N-1:0] d;

      nreset = 1'b0;
      req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hFF; pad_in = 8'h00;
      c_req_valid = 1'b1; c_req_write = 1'b1; c_req_wdata = 8'hFF; c_pad_in = 8'h00;
      repeat (3) tick();
      check_eq("rst_ready", req_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_oe", pad_oe, 8'h00);
      check_eq("rst_out", pad_out, 8'h00);
      check_eq("rst_stb", {wr_stb, rd_stb, rsp_valid}, 3'b000);
      check_eq("rst_data", rsp_data, 8'h00);
      check_eq("rst_c_oe", c_pad_oe, 8'h00);
      req_valid = 1'b0; c_req_valid = 1'b0;
      nreset = 1'b1;
      tick();

      do_req(1'b1, 8'hA5, w);
      check_eq("wr_accept_wait", w, 0);
      write_profile(D_S, D_H, D_T, 8'hA5);

      do_req(1'b0, 8'h3C, w);
      read_profile(D_RW, 8'h3C);

      // back-to-back with req_valid held high throughout
      wait_idle();
      do_req(1'b1, 8'h11, w);
      do_req(1'b0, 8'h22, w);
      check_eq("b2b_rd_wait", w, D_S + D_H + D_T + 1);
      check_eq("b2b_rd_oe", pad_oe, 8'h00);
      do_req(1'b1, 8'h33, w);
      check_eq("b2b_wr_wait", w, D_RW);
      check_eq("b2b_wr_oe", pad_oe, 8'hFF);
      drv_req(1'b0, 1'b0, 8'h00);
      wait_idle();

      // async reset while the write strobe is high
      do_req(1'b1, 8'h5A, w);
      drv_req(1'b0, 1'b0, 8'h00);
      tick();
      tick();
      check_eq("pre_rst_stb", wr_stb, 1'b1);
      #2 nreset = 1'b0;
      #1;
      check_eq("arst_oe", pad_oe, 8'h00);
      check_eq("arst_wr", wr_stb, 1'b0);
      check_eq("arst_out", pad_out, 8'h00);
      check_eq("arst_ready", req_ready, 1'b1);
      #3 nreset = 1'b1;
      wr_q.delete();
      tick();

      // async reset during a read: no response may follow
      do_req(1'b0, 8'h77, w);
      drv_req(1'b0, 1'b0, 8'h00);
      check_eq("pre_rst_rd", rd_stb, 1'b1);
      #2 nreset = 1'b0;
      #1;
      check_eq("arst_rd", rd_stb, 1'b0);
      #3 nreset = 1'b1;
      rd_q.delete();
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("abort_no_rsp", rsp_valid, 1'b0);
      end

      // minimum-timing corner instance
      sel = 1'b1;
      tick();
      do_req(1'b1, 8'hC3, w);
      write_profile(C_S, C_H, C_T, 8'hC3);
      do_req(1'b0, 8'hE1, w);
      read_profile(C_RW, 8'hE1);
      wait_idle();

      // random stream on the default instance
      sel = 1'b0;
      tick();
      prev_exp = 0;
      for (int n = 0; n < 40; n++) begin
         gap = $urandom_range(0, 2);
         wr  = 1'($urandom_range(0, 1));
         d   = 8'($urandom);
         if (gap > 0) begin
            drv_req(1'b0, 1'b0, 8'h00);
            repeat (gap) tick();
         end
         do_req(wr, d, w);
         check_eq("rand_wait", w, (prev_exp > gap) ? prev_exp - gap : 0);
         prev_exp = wr ? (D_S + D_H + D_T + 1) : D_RW;
      end
      drv_req(1'b0, 1'b0, 8'h00);
      wait_idle();
      repeat (3) tick();
      check_eq("wr_q_left", wr_q.size(), 0);
      check_eq("rd_q_left", rd_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bidir_bus_ctrl.md
# bidir_bus_ctrl

Sequencer for an N-bit half-duplex parallel pad bus built from a tristate pad bank. It accepts single read/write requests from an on-chip host over a valid/ready handshake and drives the pad bank's per-bit output-enable and output data. It generates write/read strobes with programmable setup, hold, turnaround and read-wait cycles, and returns the sampled read data. It guarantees the pads are never driven while the external device may be driving the bus.

## Interface
- N, 8: bus width in bits.
- SETUP, 2: cycles data is driven before wr_stb (≥1).
- HOLD, 1: cycles data stays driven after wr_stb (≥0; 0 skips hold).
- TA, 1: turnaround cycles with pads released after a write (≥1).
- RD_WAIT, 2: cycles rd_stb is asserted before sampling (≥1).

- clk  in  1  single clock.
- nreset  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read; sampled on acceptance.
- req_wdata  in  N  write data; sampled on acceptance.
- rsp_valid  out  1  one-cycle pulse; rsp_data holds read result.
- rsp_data  out  N  last read data; holds until the next read completes.
- pad_oe  out  N  to pad bank output enable; all bits always equal.
- pad_out  out  N  to pad bank output data.
- pad_in  in  N  from pad bank input; synchronous to clk, not resynchronised.
- wr_stb  out  1  write strobe to external device.
- rd_stb  out  1  read strobe to external device.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, WSETUP, WSTROBE, WHOLD, TURN, RWAIT.
- Acceptance occurs at a rising edge with req_valid & req_ready. req_ready = (state == IDLE), combinational from the state register.
- Write path: IDLE → WSETUP (SETUP cycles) → WSTROBE (1 cycle) → WHOLD (HOLD cycles, skipped if 0) → TURN (TA cycles) → IDLE.
- Read path: IDLE → RWAIT (RD_WAIT cycles) → IDLE.
- pad_oe is all-ones in WSETUP, WSTROBE and WHOLD, and all-zeros in every other state.
- pad_out is loaded with req_wdata on write acceptance and holds that value until the next write acceptance.
- wr_stb = 1 only in WSTROBE. rd_stb = 1 only in RWAIT.
- On the last RWAIT cycle's closing edge: pad_in → rsp_data, and rsp_valid is set for exactly the next cycle.
- The down-counter is sized $clog2(max(SETUP,HOLD,TA,RD_WAIT)+1). It loads param−1 on state entry and the state exits when the counter is 0.
- All outputs except req_ready and busy are registered.
- Requests arriving while busy are ignored, not queued. req_valid may stay high; no request is lost because req_ready is low.
- Reset values: state IDLE, pad_oe 0, pad_out 0, wr_stb 0, rd_stb 0, rsp_valid 0, rsp_data 0, counter 0. req_ready is therefore 1 and busy 0.
- Reset asserted mid-operation releases the pads (pad_oe = 0) and drops the strobes immediately (asynchronously). No rsp_valid is produced for an aborted read.

## Timing
- Notation: acceptance at edge k; cycle k+1 is the first cycle after it.
- Write: pad_oe = 1 and pad_out = wdata in cycles k+1 … k+SETUP.
  - wr_stb is high in cycle k+SETUP+1.
  - Hold occupies cycles k+SETUP+2 … k+SETUP+1+HOLD.
  - pad_oe = 0 for the next TA cycles.
  - req_ready is high in cycle k+SETUP+HOLD+TA+2.
  - Defaults: pads driven k+1…k+4, strobe k+3, TURN k+5, ready k+6.
- Read: rd_stb = 1 and pad_oe = 0 in cycles k+1 … k+RD_WAIT.
  - rsp_valid and req_ready are both high in cycle k+RD_WAIT+1.
  - Defaults: rd_stb k+1…k+2, rsp_valid k+3.
- Back-to-back: a new request may be accepted at the edge ending the first IDLE cycle. A read followed by a write needs no turnaround, because reads never drive the pads.
- pad_oe never transitions 0→1 in the cycle immediately after rd_stb = 1 unless the state passes through IDLE. This costs at least one released cycle.

## Test plan
- Reset: hold nreset low with req_valid = 1 → all outputs at reset values and req_ready = 1. Assert nreset low during WSTROBE → pad_oe and wr_stb fall without a clock edge.
- Single write, defaults, wdata = 8'hA5, accepted at k:
  - pad_oe = 8'hFF and pad_out = 8'hA5 in k+1…k+4.
  - wr_stb in k+3 only.
  - pad_oe = 0 in k+5.
  - req_ready returns in k+6.
- Single read, defaults, pad_in = 8'h3C during k+2:
  - rd_stb in k+1…k+2, pad_oe = 0 throughout.
  - rsp_valid one cycle at k+3 with rsp_data = 8'h3C.
  - rsp_data holds 8'h3C afterwards.
- Back-to-back write→read→write with req_valid held high:
  - Each transaction is accepted on the first IDLE cycle.
  - A TA cycle with pad_oe = 0 separates the write from the following read.
  - The read completes before the next drive begins.
- Parameter corners, HOLD = 0, TA = 1, SETUP = 1, RD_WAIT = 1:
  - Write: drive k+1, strobe k+2, release k+3, ready k+4.
  - Read: rsp_valid at k+2.
- Assertion check across a random request stream: pad_oe is always all-0 or all-1, never 1 while rd_stb = 1, and wr_stb and rd_stb are never high simultaneously.
